// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_timing_gen_if : raster timing bundle, generator -> display/pixel   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface vga_timing_gen_if;
  logic       pixel_tick;
  logic       h_sync;
  logic       v_sync;
  logic       DE;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       frame_start;

  modport master (
    output pixel_tick, h_sync, v_sync, DE, x_pixel, y_pixel, frame_start
  );

  modport slave (
    input pixel_tick, h_sync, v_sync, DE, x_pixel, y_pixel, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_timing_gen : 640x480@60 raster timing from a divided system clock  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0]       H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the 10-bit counters");
  end

  if (DIV < 2 || DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: DIV must lie in 2..16");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             pixel_tick;
  logic             h_last;

  assign pixel_tick = (div_cnt_q == DIV_LAST);
  assign h_last     = (h_cnt_q == H_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pixel_tick) begin
      div_cnt_d = '0;
      h_cnt_d   = h_last ? 10'd0 : h_cnt_q + 10'd1;
      // Line wrap carries into the vertical counter on the same tick.
      if (h_last) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Decode straight from the counter registers so every output shares their timing.
  assign vga.pixel_tick  = pixel_tick;
  assign vga.x_pixel     = h_cnt_q;
  assign vga.y_pixel     = v_cnt_q;
  assign vga.DE          = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
  assign vga.h_sync      = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ?
                           SYNC_POL : ~SYNC_POL;
  assign vga.v_sync      = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ?
                           SYNC_POL : ~SYNC_POL;
  assign vga.frame_start = pixel_tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// tb_vga_timing_gen: closed-form raster model checked every cycle against a
// default 640x480 instance and a small, odd-divider, active-high-sync instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if if0();
  vga_timing_gen_if if1();

  vga_timing_gen dut0 (
    .clk   (clk),
    .reset (reset),
    .vga   (if0)
  );

  vga_timing_gen #(
    .DIV(3), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .vga   (if1)
  );

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  int n_chk = 0;
  int n_err = 0;
  int n = 0;          // clocks since the last reset edge
  bit started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n       <= 0;
      started <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // Pixel index = clocks/DIV; raster position follows by division and modulo.
  function automatic obs_t model(int cyc, int div, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, bit pol);
    obs_t e;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    int p  = cyc / div;
    int x  = p % ht;
    int y  = (p / ht) % vt;
    e.tick = ((cyc % div) == div - 1);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.de   = (x < hv) && (y < vv);
    e.hs   = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
    e.vs   = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
    e.fs   = e.tick && x == 0 && y == 0;
    return e;
  endfunction

  function automatic obs_t grab0();
    obs_t a;
    a.tick = if0.pixel_tick; a.hs = if0.h_sync; a.vs = if0.v_sync;
    a.de = if0.DE; a.fs = if0.frame_start; a.x = if0.x_pixel; a.y = if0.y_pixel;
    return a;
  endfunction

  function automatic obs_t grab1();
    obs_t a;
    a.tick = if1.pixel_tick; a.hs = if1.h_sync; a.vs = if1.v_sync;
    a.de = if1.DE; a.fs = if1.frame_start; a.x = if1.x_pixel; a.y = if1.y_pixel;
    return a;
  endfunction

  task automatic cmp_obs(string name, obs_t a, obs_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s n=%0d got tick=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b want tick=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b",
               name, n, a.tick, a.x, a.y, a.de, a.hs, a.vs, a.fs,
               e.tick, e.x, e.y, e.de, e.hs, e.vs, e.fs);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      cmp_obs("dut0_raster", grab0(), model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      cmp_obs("dut1_raster", grab1(), model(n, 3, 16, 2, 4, 3, 10, 2, 2, 3, 1'b1));
    end
  end

  // Whole-frame properties of the small instance: spacing, DE ticks, v_sync ticks.
  int last_fs = -1;
  int de_ticks = 0;
  int vs_ticks = 0;
  always @(negedge clk) begin
    if (started) begin
      if (n == 0) begin
        last_fs  = -1;
        de_ticks = 0;
        vs_ticks = 0;
      end
      if (if1.pixel_tick) begin
        if (if1.frame_start) begin
          if (last_fs >= 0) begin
            chk("dut1_frame_spacing", n - last_fs, 1275);
            chk("dut1_de_ticks", de_ticks, 160);
            chk("dut1_vsync_ticks", vs_ticks, 50);
          end
          last_fs  = n;
          de_ticks = 0;
          vs_ticks = 0;
        end
        if (if1.DE) de_ticks++;
        if (if1.v_sync) vs_ticks++;
      end
    end
  end

  task automatic wait_n(int t);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (n != t && guard < 200000);
    if (n != t) chk("wait_timeout", n, t);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    wait_n(0);
    chk("rst_x", if0.x_pixel, 0);
    chk("rst_y", if0.y_pixel, 0);
    chk("rst_de", if0.DE, 1);
    chk("rst_hs", if0.h_sync, 1);
    chk("rst_vs", if0.v_sync, 1);
    chk("rst_tick", if0.pixel_tick, 0);
    chk("rst_fs", if0.frame_start, 0);
    chk("rst_hs_pol1", if1.h_sync, 0);
    wait_n(2);    chk("tick_n2", if0.pixel_tick, 0);
    wait_n(3);    chk("tick_n3", if0.pixel_tick, 1);
                  chk("fs_n3", if0.frame_start, 1);
    wait_n(4);    chk("x_n4", if0.x_pixel, 1);
                  chk("fs_n4", if0.frame_start, 0);
    wait_n(1274); chk("dut1_x_end", if1.x_pixel, 24);
                  chk("dut1_y_end", if1.y_pixel, 16);
    wait_n(1275); chk("dut1_x_wrap", if1.x_pixel, 0);
                  chk("dut1_y_wrap", if1.y_pixel, 0);
    wait_n(1277); chk("dut1_fs_wrap", if1.frame_start, 1);
    wait_n(2559); chk("de_x639", if0.DE, 1);
    wait_n(2560); chk("de_x640", if0.DE, 0);
    wait_n(2623); chk("hs_x655", if0.h_sync, 1);
    wait_n(2624); chk("hs_x656", if0.h_sync, 0);
    wait_n(3007); chk("hs_x751", if0.h_sync, 0);
    wait_n(3008); chk("hs_x752", if0.h_sync, 1);
    wait_n(3199); chk("x_799", if0.x_pixel, 799);
                  chk("y_line0", if0.y_pixel, 0);
    wait_n(3200); chk("x_wrap", if0.x_pixel, 0);
                  chk("y_line1", if0.y_pixel, 1);
    wait_n(3203); chk("fs_line1", if0.frame_start, 0);
    wait_n(4001);

    // One-clock reset landing while the divider sits at phase 2.
    wait_n(4001 + 4 * 10);
    @(posedge clk);
    #1 reset = 1'b1;
    chk("pre_rst_phase", n % 4, 2);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_x", if0.x_pixel, 0);
    chk("mid_rst_tick", if0.pixel_tick, 0);
    wait_n(3);
    chk("mid_rst_fs", if0.frame_start, 1);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(300, 4000)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (4000) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
